capture_ctrl: RTL and testbench

Capture sequencer for the digital storage oscilloscope front end. It arms the trigger path, writes decimated samples into the circular sample RAM, and counts post-trigger samples. When the post-trigger count is reached it signals capture completion. It drives `armed` and `set_capture_done` into the trigger logic and consumes its sticky `triggered` output.

---
 rtl/capture_pkg.sv | 16 +
 rtl/circ_addr_cnt.sv | 27 ++
 rtl/capture_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_capture_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// Shared definitions for the capture sequencer: state encoding and default
// sample RAM geometry.
package capture_pkg;

  localparam int CAP_ADDR_W = 9;
  localparam int CAP_DEPTH  = 2 ** CAP_ADDR_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } cap_state_t;

endpackage

// File: rtl/circ_addr_cnt.sv
// Circular address counter for the sample RAM write pointer; wraps naturally
// from 2**ADDR_W-1 back to 0.
module circ_addr_cnt #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] cnt_o
);

  logic [ADDR_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + ADDR_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/capture_ctrl.sv
// Capture sequencer: fills the pre-trigger region, arms the trigger path,
// counts post-trigger samples and freezes the circular sample RAM on completion.
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int ADDR_W = CAP_ADDR_W,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap_en,
  input  logic              smpl_en,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic              triggered,
  input  logic              done_clr,
  output logic              armed,
  output logic              set_capture_done,
  output logic              capture_done,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] end_addr
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

  cap_state_t        state_q, state_d;
  logic [ADDR_W-1:0] tp_q, tp_d;
  logic [ADDR_W:0]   smpl_cnt_q, smpl_cnt_d;
  logic [ADDR_W-1:0] trig_cnt_q, trig_cnt_d;
  logic              armed_q, armed_d;
  logic              done_q, done_d;
  logic              set_done_q, set_done_d;
  logic [ADDR_W-1:0] end_addr_q, end_addr_d;

  logic              wr;
  logic              waddr_clr;
  logic [ADDR_W:0]   smpl_inc;
  logic [ADDR_W:0]   pre_sum;
  logic [ADDR_W-1:0] trig_inc;
  logic [ADDR_W-1:0] waddr_inc;

  circ_addr_cnt #(.ADDR_W(ADDR_W)) u_waddr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (waddr_clr),
    .inc_i (wr),
    .cnt_o (waddr)
  );

  assign smpl_inc  = (smpl_cnt_q == DEPTH_C) ? smpl_cnt_q : smpl_cnt_q + CNT_ONE;
  assign pre_sum   = smpl_inc + {1'b0, tp_q};
  assign trig_inc  = trig_cnt_q + ADDR_W'(1);
  assign waddr_inc = waddr + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tp_q       <= '0;
      smpl_cnt_q <= '0;
      trig_cnt_q <= '0;
      armed_q    <= 1'b0;
      done_q     <= 1'b0;
      set_done_q <= 1'b0;
      end_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      tp_q       <= tp_d;
      smpl_cnt_q <= smpl_cnt_d;
      trig_cnt_q <= trig_cnt_d;
      armed_q    <= armed_d;
      done_q     <= done_d;
      set_done_q <= set_done_d;
      end_addr_q <= end_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tp_d       = tp_q;
    smpl_cnt_d = smpl_cnt_q;
    trig_cnt_d = trig_cnt_q;
    armed_d    = armed_q;
    done_d     = done_q;
    set_done_d = 1'b0;
    end_addr_d = end_addr_q;
    wr         = 1'b0;
    waddr_clr  = 1'b0;

    unique case (state_q)
      IDLE: begin
        waddr_clr  = 1'b1;
        smpl_cnt_d = '0;
        trig_cnt_d = '0;
        armed_d    = 1'b0;
        if (cap_en) begin
          tp_d    = trig_pos;
          state_d = PRE;
        end
      end

      PRE: begin
        if (!cap_en) begin
          state_d   = IDLE;
          armed_d   = 1'b0;
          waddr_clr = 1'b1;
        end else if (smpl_en) begin
          wr         = 1'b1;
          smpl_cnt_d = smpl_inc;
          if (pre_sum >= DEPTH_C) begin
            armed_d = 1'b1;
            state_d = ARMED;
          end
        end
      end

      ARMED: begin
        if (!cap_en) begin
          state_d   = IDLE;
          armed_d   = 1'b0;
          waddr_clr = 1'b1;
        end else if (triggered && (tp_q == '0)) begin
          // No post-trigger region: freeze right here without writing.
          state_d    = DONE;
          armed_d    = 1'b0;
          done_d     = 1'b1;
          set_done_d = 1'b1;
          end_addr_d = waddr;
        end else begin
          wr = smpl_en;
          if (triggered) begin
            if (smpl_en && (tp_q == ADDR_W'(1))) begin
              state_d    = DONE;
              armed_d    = 1'b0;
              done_d     = 1'b1;
              set_done_d = 1'b1;
              end_addr_d = waddr_inc;
            end else begin
              state_d    = POST;
              trig_cnt_d = smpl_en ? ADDR_W'(1) : '0;
            end
          end
        end
      end

      POST: begin
        if (!cap_en) begin
          state_d   = IDLE;
          armed_d   = 1'b0;
          waddr_clr = 1'b1;
        end else if (smpl_en) begin
          wr         = 1'b1;
          trig_cnt_d = trig_inc;
          if (trig_inc == tp_q) begin
            state_d    = DONE;
            armed_d    = 1'b0;
            done_d     = 1'b1;
            set_done_d = 1'b1;
            end_addr_d = waddr_inc;
          end
        end
      end

      DONE: begin
        if (done_clr) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign we               = wr;
  assign armed            = armed_q;
  assign set_capture_done = set_done_q;
  assign capture_done     = done_q;
  assign end_addr         = end_addr_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl: every expected write address is queued as
// the stimulus is driven and popped when the DUT asserts we.
module tb_capture_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          cap_en    = 1'b0;
  logic          smpl_en   = 1'b0;
  logic          triggered = 1'b0;
  logic          done_clr  = 1'b0;
  logic [AW-1:0] trig_pos  = '0;
  logic          armed, set_capture_done, capture_done, we;
  logic [AW-1:0] waddr, end_addr;

  int n_vec    = 0;
  int n_err    = 0;
  int exp_addr = 0;
  int mon_e;
  int wr_q[$];

  always #5 clk = ~clk;

  capture_ctrl #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cap_en           (cap_en),
    .smpl_en          (smpl_en),
    .trig_pos         (trig_pos),
    .triggered        (triggered),
    .done_clr         (done_clr),
    .armed            (armed),
    .set_capture_done (set_capture_done),
    .capture_done     (capture_done),
    .we               (we),
    .waddr            (waddr),
    .end_addr         (end_addr)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Any cycle with a queued entry must write that address; any other write is spurious.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_q.size() > 0) begin
        mon_e = wr_q.pop_front();
        chk("we", we, 1);
        chk("waddr", waddr, mon_e);
      end else if (we) begin
        chk("we_spurious", we, 0);
      end
    end
  end

  task automatic cyc(input logic s, input logic tr, input logic wr_exp);
    smpl_en   = s;
    triggered = tr;
    if (wr_exp) begin
      wr_q.push_back(exp_addr);
      exp_addr = (exp_addr + 1) % DEPTH;
    end
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int tp);
    trig_pos = AW'(tp);
    cap_en   = 1'b1;
    exp_addr = 0;
    cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic fill(input int n, input logic tr, input int gap);
    for (int i = 0; i < n; i++) begin
      chk("armed_pre", armed, 0);
      cyc(1'b1, tr, 1'b1);
      if (i < n - 1) begin
        for (int g = 0; g < gap; g++) cyc(1'b0, tr, 1'b0);
      end
    end
  endtask

  task automatic expect_done();
    chk("set_done", set_capture_done, 1);
    chk("cap_done", capture_done, 1);
    chk("armed_done", armed, 0);
    chk("end_addr", end_addr, exp_addr);
    chk("waddr_done", waddr, exp_addr);
    $display("capture complete tp=%0d end_addr=%0d", trig_pos, end_addr);
    cyc(1'b1, 1'b0, 1'b0);
    chk("set_done_pulse", set_capture_done, 0);
    chk("cap_done_hold", capture_done, 1);
  endtask

  task automatic release_done();
    cap_en = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    chk("cap_done_no_abort", capture_done, 1);
    done_clr = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    done_clr = 1'b0;
    chk("cap_done_clr", capture_done, 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("waddr_idle", waddr, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_armed", armed, 0);
    chk("rst_set_done", set_capture_done, 0);
    chk("rst_cap_done", capture_done, 0);
    chk("rst_we", we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_end_addr", end_addr, 0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);

    // Normal capture: 12 pre writes, 5 armed writes, trigger, 4 post writes.
    start(4);
    fill(12, 1'b0, 0);
    chk("armed_rise", armed, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 1'b1);
      chk("armed_hold", armed, 1);
    end
    for (int i = 0; i < 4; i++) begin
      chk("set_done_early", set_capture_done, 0);
      cyc(1'b1, 1'b1, 1'b1);
    end
    expect_done();
    release_done();

    // Wrap: long armed phase makes the pointer wrap twice.
    start(2);
    fill(14, 1'b0, 0);
    chk("armed_rise_wrap", armed, 1);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    expect_done();
    release_done();

    // Zero post-trigger samples: trigger freezes without writing.
    start(0);
    fill(16, 1'b0, 0);
    chk("armed_rise_tp0", armed, 1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    expect_done();
    release_done();

    // Early trigger ignored in PRE, then abort midway through POST.
    start(4);
    fill(11, 1'b1, 0);
    chk("armed_early_trig", armed, 0);
    cyc(1'b1, 1'b0, 1'b1);
    chk("armed_rise_early", armed, 1);
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    cap_en = 1'b0;
    cyc(1'b1, 1'b1, 1'b0);
    chk("abort_armed", armed, 0);
    chk("abort_set_done", set_capture_done, 0);
    chk("abort_cap_done", capture_done, 0);
    chk("abort_waddr", waddr, 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("abort_set_done2", set_capture_done, 0);
    $display("capture aborted tp=%0d waddr=%0d", trig_pos, waddr);

    // Sparse samples: one sample every third cycle.
    start(8);
    fill(8, 1'b0, 2);
    chk("armed_rise_sparse", armed, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("set_done_sparse_early", set_capture_done, 0);
      cyc(1'b1, 1'b1, 1'b1);
      if (i < 7) begin
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
      end
    end
    expect_done();
    release_done();

    // Asynchronous reset while armed.
    start(4);
    fill(12, 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("armed_before_rst", armed, 1);
    smpl_en = 1'b1;
    rst_n   = 1'b0;
    #1;
    chk("arst_armed", armed, 0);
    chk("arst_set_done", set_capture_done, 0);
    chk("arst_cap_done", capture_done, 0);
    chk("arst_we", we, 0);
    chk("arst_waddr", waddr, 0);
    chk("arst_end_addr", end_addr, 0);
    $display("reset applied while armed");
    cap_en  = 1'b0;
    smpl_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk("post_rst_we", we, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
